// File: rtl/pipeline_assign.sv
// Four-stage register/ALU/memory pipeline: read, execute, register write-back, memory write.
// Define PIPELINE_MUL_EN to enable the multiplier for opcode 2; otherwise opcode 2 yields 0.
module pipeline_assign (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    input  logic [3:0]  rd,
    input  logic [3:0]  func,
    input  logic [7:0]  addr,
    output logic [15:0] Z
);

    logic [15:0] regbank [0:15];
    logic [15:0] mem     [0:255];

    // Stage 1: operands and control.
    logic [15:0] a1, b1;
    logic [3:0]  rd1, func1;
    logic [7:0]  addr1;
    logic        v1;

    // Stage 2: Z itself is the stage-2 result register.
    logic [3:0]  rd2;
    logic [7:0]  addr2;
    logic        v2;

    // Stage 3: result and address held for the memory write.
    logic [15:0] z3;
    logic [7:0]  addr3;
    logic        v3;

    logic [15:0] alu_y;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves alu_y unassigned (no latch).
        alu_y = '0;
        case (func1)
            4'd0:  alu_y = a1 + b1;
            4'd1:  alu_y = a1 - b1;
`ifdef PIPELINE_MUL_EN
            4'd2:  alu_y = a1 * b1;
`else
            4'd2:  alu_y = '0;
`endif
            4'd3:  alu_y = a1;
            4'd4:  alu_y = b1;
            4'd5:  alu_y = a1 & b1;
            4'd6:  alu_y = a1 | b1;
            4'd7:  alu_y = a1 ^ b1;
            4'd8:  alu_y = -a1;
            4'd9:  alu_y = -b1;
            4'd10: alu_y = a1 >> 1;
            4'd11: alu_y = a1 << 1;
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            a1    <= '0;
            b1    <= '0;
            rd1   <= '0;
            func1 <= '0;
            addr1 <= '0;
            v1    <= 1'b0;
            Z     <= '0;
            rd2   <= '0;
            addr2 <= '0;
            v2    <= 1'b0;
            z3    <= '0;
            addr3 <= '0;
            v3    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates mean a read here sees regbank before this edge's write-back.
            a1    <= regbank[rs1];
            b1    <= regbank[rs2];
            rd1   <= rd;
            func1 <= func;
            addr1 <= addr;
            v1    <= 1'b1;
            Z     <= alu_y;
            rd2   <= rd1;
            addr2 <= addr1;
            v2    <= v1;
            z3    <= Z;
            addr3 <= addr2;
            v3    <= v2;
        end
    end

    // NOTE: storage arrays carry no reset; in-flight writes are suppressed by the cleared valid flags.
    always_ff @(posedge clk1) begin
        if (v2) regbank[rd2] <= Z;
        if (v3) mem[addr3]   <= z3;
    end

endmodule

// File: tb/tb_pipeline_assign.sv
// Randomized scoreboard bench for pipeline_assign: a per-edge reference model predicts Z,
// register write-back and memory writes; a negedge monitor compares them when due.
module tb_pipeline_assign;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rs1 = '0, rs2 = '0, rd = '0, func = '0;
    logic [7:0]  addr = '0;
    logic [15:0] Z;

    pipeline_assign dut (
        .clk1 (clk1),
        .rst_n(rst_n),
        .rs1  (rs1),
        .rs2  (rs2),
        .rd   (rd),
        .func (func),
        .addr (addr),
        .Z    (Z)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        int          due;
        int          idx;
        logic [15:0] val;
    } chk_t;

    typedef struct {
        bit          live;
        int          issued;
        logic [3:0]  rd;
        logic [7:0]  addr;
        logic [15:0] z;
    } rec_t;

    chk_t q_z[$], q_reg[$], q_mem[$];
    rec_t rec [0:3];
    logic [15:0] m_reg [16];
    logic [15:0] m_mem [256];
    int edge_n = 0;
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
        int unsigned ua, ub, r;
        ua = a;
        ub = b;
        case (op)
            4'd0:  r = ua + ub;
            4'd1:  r = ua + 65536 - ub;
`ifdef PIPELINE_MUL_EN
            4'd2:  r = ua * ub;
`else
            4'd2:  r = 0;
`endif
            4'd3:  r = ua;
            4'd4:  r = ub;
            4'd5:  r = ua & ub;
            4'd6:  r = ua | ub;
            4'd7:  r = ua ^ ub;
            4'd8:  r = 65536 - ua;
            4'd9:  r = 65536 - ub;
            4'd10: r = ua / 2;
            4'd11: r = ua * 2;
            default: r = 0;
        endcase
        return 16'(r % 65536);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // One instruction per edge: drive at negedge, then advance the model at the posedge.
    task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                         input logic [3:0] f, input logic [7:0] ad);
        logic [15:0] a, b, z;
        rec_t r;
        @(negedge clk1);
        rs1 = s1; rs2 = s2; rd = d; func = f; addr = ad;
        @(posedge clk1);
        edge_n++;
        a = m_reg[s1];
        b = m_reg[s2];
        z = ref_alu(a, b, f);
        r = rec[(edge_n + 2) % 4];
        if (r.live && r.issued == edge_n - 2) m_reg[r.rd] = r.z;
        r = rec[(edge_n + 1) % 4];
        if (r.live && r.issued == edge_n - 3) m_mem[r.addr] = r.z;
        rec[edge_n % 4] = '{live: 1'b1, issued: edge_n, rd: d, addr: ad, z: z};
        q_z.push_back('{due: edge_n + 1, idx: 0, val: z});
        q_reg.push_back('{due: edge_n + 2, idx: int'(d), val: z});
        q_mem.push_back('{due: edge_n + 3, idx: int'(ad), val: z});
    endtask

    task automatic filler();
        issue(4'd15, 4'd15, 4'd15, 4'd12, 8'd250);
    endtask

    task automatic issue_random();
        issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    endtask

    always @(negedge clk1) begin
        chk_t c;
        while (q_z.size() > 0 && q_z[0].due <= edge_n) begin
            c = q_z.pop_front();
            check("z", Z, c.val);
        end
        while (q_reg.size() > 0 && q_reg[0].due <= edge_n) begin
            c = q_reg.pop_front();
            check($sformatf("regbank[%0d]", c.idx), dut.regbank[c.idx], c.val);
        end
        while (q_mem.size() > 0 && q_mem[0].due <= edge_n) begin
            c = q_mem.pop_front();
            check($sformatf("mem[%0d]", c.idx), dut.mem[c.idx], c.val);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 4; k++) rec[k] = '{live: 1'b0, issued: -100, rd: '0, addr: '0, z: '0};
        for (int k = 0; k < 16; k++) begin
            dut.regbank[k] = 16'(k);
            m_reg[k] = 16'(k);
        end
        for (int i = 0; i < 256; i++) begin
            dut.mem[i] = 16'(i * 7 + 3);
            m_mem[i] = 16'(i * 7 + 3);
        end

        repeat (2) @(posedge clk1);
        #1;
        check("z_in_reset", Z, 16'h0000);
        @(posedge clk1);
        #1 rst_n = 1'b1;

        // Directed: ADD, MUL, stale-read SUB, shift, borrow.
        issue(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
        issue(4'd3, 4'd8, 4'd12, 4'd2, 8'd126);
        issue(4'd10, 4'd5, 4'd14, 4'd1, 8'd128);
        issue(4'd7, 4'd3, 4'd13, 4'd11, 8'd127);
        issue(4'd0, 4'd1, 4'd11, 4'd1, 8'd129);
        repeat (3) filler();
        @(negedge clk1);
        check("mem125_add", dut.mem[125], 16'd8);
        check("regbank10_add", dut.regbank[10], 16'd8);
`ifdef PIPELINE_MUL_EN
        check("mem126_mul", dut.mem[126], 16'd24);
`else
        check("mem126_mul", dut.mem[126], 16'd0);
`endif
        check("mem128_stale", dut.mem[128], 16'd5);
        check("mem127_sla", dut.mem[127], 16'd14);
        check("mem129_borrow", dut.mem[129], 16'hFFFF);

        // Directed: SUB three edges after ADD sees the written value.
        issue(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
        issue(4'd3, 4'd8, 4'd12, 4'd2, 8'd126);
        filler();
        issue(4'd10, 4'd5, 4'd14, 4'd1, 8'd128);
        repeat (3) filler();
        @(negedge clk1);
        check("mem128_fresh", dut.mem[128], 16'd3);

        repeat (200) issue_random();

        // Reset with instructions in flight.
        issue(4'd3, 4'd5, 4'd9, 4'd0, 8'd200);
        filler();
        #1 rst_n = 1'b0;
        #1 check("z_async_reset", Z, 16'h0000);
        for (int k = 0; k < 4; k++) rec[k].live = 1'b0;
        q_z.delete();
        q_reg.delete();
        q_mem.delete();
        repeat (3) @(posedge clk1);
        #1;
        check("mem200_after_reset", dut.mem[200], m_mem[200]);
        check("mem0_after_reset", dut.mem[0], m_mem[0]);
        for (int k = 0; k < 16; k++)
            check($sformatf("regbank[%0d]_after_reset", k), dut.regbank[k], m_reg[k]);
        @(posedge clk1);
        #1 rst_n = 1'b1;

        repeat (40) issue_random();
        repeat (4) filler();
        @(negedge clk1);
        for (int i = 0; i < 256; i++)
            if (dut.mem[i] !== m_mem[i]) check($sformatf("mem[%0d]_final", i), dut.mem[i], m_mem[i]);
        check("mem_final_sample", dut.mem[edge_n % 256], m_mem[edge_n % 256]);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
